// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver
//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
//   that share one segment bus. A packed nibble value is captured into a
//   shadow register on load. It is promoted to the active register only when
//   the scan wraps back to digit 0, so a displayed frame never mixes old and
//   new digits. One digit is lit per refresh slot. Each slot begins with one
//   dead cycle (all anodes off) to suppress ghosting.
//
//   Optional feature macro: SSD_LEADING_ZERO_BLANK_EN
//     Defined   : leading zero digits (i>0, this and all higher nibbles == 0)
//                 are shown blank. Their decimal point still follows dp.
//     Undefined : every digit is decoded as-is.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   load       in   one-cycle strobe, captures value/dp_in
//   value      in   packed nibbles, nibble i = digit i (digit 0 rightmost)
//   dp_in      in   decimal point request per digit, 1 = lit
//   hex_mode   in   1 = show 10-15 as A b C d E F, 0 = show them blank
//   blank      in   1 = all anodes off, scan keeps running
//   seg        out  {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   an         out  digit enables, active-low, at most one low
//   frame_done out  one-cycle pulse in the cycle after the scan wraps
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Scan state
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;

  // Double-buffered display data
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] active;
  logic [NUM_DIGITS-1:0]   active_dp;

  logic          tick;
  logic          wrap;
  logic [IW-1:0] idx_next;
  logic          lit;
  logic [3:0]    cur_nib;
  logic          cur_dp;
  logic [6:0]    cur_seg;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS-1:0] lz_mask;

  // Active-low glyph decoder. 10-15 are only shown when hex is set.
  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    g = SEG_OFF;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = hex ? 7'b0001000 : SEG_OFF;
      4'hB: g = hex ? 7'b0000011 : SEG_OFF;
      4'hC: g = hex ? 7'b1000110 : SEG_OFF;
      4'hD: g = hex ? 7'b0100001 : SEG_OFF;
      4'hE: g = hex ? 7'b0000110 : SEG_OFF;
      4'hF: g = hex ? 7'b0001110 : SEG_OFF;
      default: g = SEG_OFF;
    endcase
    return g;
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign wrap     = tick && (idx == IDX_LAST);
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // The registered outputs for the edge that ends a slot are the dead cycle,
  // so a digit is only driven when no tick is in progress and not blanked.
  assign lit = !tick && !blank;

  assign cur_nib = active[{idx, 2'b00} +: 4];
  assign cur_dp  = active_dp[idx];
  assign an_sel  = ~(NUM_DIGITS'(1) << idx);

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // lz_mask[i] = 1 when nibble i and every nibble above it are zero.
  // Digit 0 is never suppressed so a zero value still shows one '0'.
  always_comb begin
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (i == NUM_DIGITS - 1)
        lz_mask[i] = (active[4*i +: 4] == 4'h0);
      else
        lz_mask[i] = (active[4*i +: 4] == 4'h0) && lz_mask[i+1];
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign cur_seg = lz_mask[idx] ? SEG_OFF : decode(cur_nib, hex_mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      active     <= '0;
      active_dp  <= '0;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      // Refresh prescaler and digit index
      if (tick) begin
        presc <= '0;
        idx   <= idx_next;
      end else begin
        presc <= presc + 1'b1;
      end

      // Shadow capture; the last load before a wrap wins
      if (load) begin
        shadow    <= value;
        shadow_dp <= dp_in;
      end

      // Frame-atomic promotion. A load coinciding with the wrap bypasses the
      // shadow so the new frame shows it immediately and nothing stays pending.
      if (wrap) begin
        pending <= 1'b0;
        if (load) begin
          active    <= value;
          active_dp <= dp_in;
        end else if (pending) begin
          active    <= shadow;
          active_dp <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end

      frame_done <= wrap;

      // Outputs for the current index; all off on dead or blanked cycles
      if (lit) begin
        an  <= an_sel;
        seg <= cur_seg;
        dp  <= ~cur_dp;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule
